// File: rtl/onchip_arb_pkg.sv
// Shared constants and types for the on-chip RAM round-robin arbiter.
package onchip_arb_pkg;

    localparam int ARB_AW     = 10;
    localparam int ARB_DW     = 32;
    localparam int ARB_BEW    = 4;
    localparam int ARB_MAXREQ = 4;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping modulo NREQ.
module rr_pick
    import onchip_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            gnt_valid,
    output logic [1:0]      gnt_idx
);

    logic [ARB_MAXREQ-1:0] req_ext;
    logic [2:0]            cand;

    // Scan from farthest to nearest so the candidate closest to ptr is the last one kept.
    always_comb begin
        req_ext   = ARB_MAXREQ'(req);
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (req_ext[cand[1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing a single-port 1-cycle-latency RAM between NREQ Avalon-MM requesters.
// Optional per-requester saturating grant counters: define ONCHIP_ARB_STATS_EN.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int  NREQ = 2,
    parameter int  AW   = ARB_AW,
    parameter int  DW   = ARB_DW,
    localparam int BEW  = DW / 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ*AW-1:0]  m_address,
    input  logic [NREQ*BEW-1:0] m_byteenable,
    input  logic [NREQ-1:0]     m_read,
    input  logic [NREQ-1:0]     m_write,
    input  logic [NREQ*DW-1:0]  m_writedata,
    output logic [NREQ-1:0]     m_waitrequest,
    output logic [DW-1:0]       m_readdata,
    output logic [NREQ-1:0]     m_readdatavalid,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [AW-1:0]       mem_address,
    output logic [BEW-1:0]      mem_byteenable,
    output logic [DW-1:0]       mem_writedata,
    input  logic [DW-1:0]       mem_readdata,
    output logic                mem_clken,
    output logic [NREQ*16-1:0]  grant_count
);

    logic       gnt_valid;
    logic       gnt_ok;
    logic [1:0] gnt_idx;
    logic [1:0] rr_ptr;
    logic       sel_read;
    logic       sel_write;
    rd_tag_t    rd_tag;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req       (m_read | m_write),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // No command is accepted while reset is held, even though requesters may be active.
    assign gnt_ok = gnt_valid & reset_n;

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        m_waitrequest  = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                mem_address    = m_address[i*AW +: AW];
                mem_byteenable = m_byteenable[i*BEW +: BEW];
                mem_writedata  = m_writedata[i*DW +: DW];
                sel_read       = m_read[i];
                sel_write      = m_write[i];
                m_waitrequest[i] = ~gnt_ok;
            end
        end
    end

    assign mem_chipselect = gnt_ok;
    assign mem_write      = gnt_ok & sel_write;
    assign mem_clken      = 1'b1;
    assign m_readdata     = mem_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr       <= 2'd0;
            rd_tag.valid <= 1'b0;
            rd_tag.idx   <= 2'd0;
        end else begin
            if (gnt_ok) begin
                rr_ptr <= (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
            end
            // A simultaneous read+write is treated as a write, so no read data follows.
            rd_tag.valid <= gnt_ok & sel_read & ~sel_write;
            rd_tag.idx   <= gnt_idx;
        end
    end

    always_comb begin
        m_readdatavalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_readdatavalid[i] = rd_tag.valid && (rd_tag.idx == 2'(i));
        end
    end

`ifdef ONCHIP_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_ok && gnt_idx == 2'(i) && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_count[i*16 +: 16] = grant_cnt[i];
        end
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter (NREQ=2) with a behavioural 1024x32 RAM.
module tb_onchip_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BEW  = 4;

    logic                clk;
    logic                reset_n;
    logic [NREQ*AW-1:0]  m_address;
    logic [NREQ*BEW-1:0] m_byteenable;
    logic [NREQ-1:0]     m_read;
    logic [NREQ-1:0]     m_write;
    logic [NREQ*DW-1:0]  m_writedata;
    logic [NREQ-1:0]     m_waitrequest;
    logic [DW-1:0]       m_readdata;
    logic [NREQ-1:0]     m_readdatavalid;
    logic                mem_chipselect;
    logic                mem_write;
    logic [AW-1:0]       mem_address;
    logic [BEW-1:0]      mem_byteenable;
    logic [DW-1:0]       mem_writedata;
    logic [DW-1:0]       mem_readdata;
    logic                mem_clken;
    logic [NREQ*16-1:0]  grant_count;

    logic [DW-1:0] ram [1024];
    int n_cmp = 0;
    int n_err = 0;
    int n_rdv0;
    int n_rdv1;

`ifdef ONCHIP_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    onchip_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_address       (m_address),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_clken       (mem_clken),
        .grant_count     (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, registered q, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BEW; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    function automatic logic [31:0] pat(input logic [9:0] a);
        return {22'h15A5A5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic rd, input logic wr, input logic [9:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        m_read[i]                  = rd;
        m_write[i]                 = wr;
        m_address[i*AW +: AW]      = a;
        m_byteenable[i*BEW +: BEW] = be;
        m_writedata[i*DW +: DW]    = wd;
    endtask

    task automatic idle();
        m_read  = '0;
        m_write = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) ram[a] = pat(10'(a));
        reset_n      = 1'b0;
        m_address    = '0;
        m_byteenable = '1;
        m_writedata  = '0;
        m_read       = 2'b11;
        m_write      = 2'b00;
        drive(1, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);

        // 1: reset with both reading
        repeat (2) @(negedge clk);
        chk("rst_wait", m_waitrequest, 2'b11);
        chk("rst_cs", mem_chipselect, 1'b0);
        chk("rst_rdv", m_readdatavalid, 2'b00);
        chk("rst_gc", grant_count, 32'h0);
        chk("clken", mem_clken, 1'b1);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_wait_m0", m_waitrequest, 2'b10);
        chk("rel_cs", mem_chipselect, 1'b1);
        chk("rel_addr", mem_address, 10'h000);
        tick();
        @(negedge clk);
        chk("rel_wait_m1", m_waitrequest, 2'b01);
        chk("rel_rdv_m0", m_readdatavalid, 2'b01);
        tick();
        idle();
        @(negedge clk);
        chk("rel_rdv_m1", m_readdatavalid, 2'b10);
        chk("idle_cs", mem_chipselect, 1'b0);

        // 2: write then read-after-write
        drive(0, 1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_memwrite", mem_write, 1'b1);
        chk("wr_wait", m_waitrequest, 2'b10);
        chk("wr_data", mem_writedata, 32'hDEADBEEF);
        tick();
        drive(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        @(negedge clk);
        chk("wr_no_rdv", m_readdatavalid, 2'b00);
        chk("rd_memwrite", mem_write, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("raw_rdv", m_readdatavalid, 2'b01);
        chk("raw_data", m_readdata, 32'hDEADBEEF);

        // read+write together: write wins, no read data
        drive(0, 1'b1, 1'b1, 10'h006, 4'hF, 32'h12345678);
        @(negedge clk);
        chk("rw_memwrite", mem_write, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("rw_no_rdv", m_readdatavalid, 2'b00);
        drive(0, 1'b1, 1'b0, 10'h006, 4'hF, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("rw_readback", m_readdata, 32'h12345678);

        // reset during a pending read
        drive(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        tick();
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        chk("midrst_rdv", m_readdatavalid, 2'b00);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_rdv", m_readdatavalid, 2'b00);
        chk("postrst_wait", m_waitrequest, 2'b11);
        tick();

        // 3: both read continuously, alternate from m0
        n_rdv0 = 0;
        n_rdv1 = 0;
        drive(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("alt_wait", m_waitrequest, (c % 2 == 0) ? 2'b10 : 2'b01);
            if (c > 0) begin
                chk("alt_rdv", m_readdatavalid, ((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
                chk("alt_data", m_readdata, ((c - 1) % 2 == 0) ? 32'hDEADBEEF : pat(10'h3FF));
            end
            n_rdv0 += int'(m_readdatavalid[0]);
            n_rdv1 += int'(m_readdatavalid[1]);
            tick();
        end
        idle();
        @(negedge clk);
        chk("alt_rdv_last", m_readdatavalid, 2'b10);
        n_rdv0 += int'(m_readdatavalid[0]);
        n_rdv1 += int'(m_readdatavalid[1]);
        chk("alt_cnt_m0", 64'(n_rdv0), 64'd3);
        chk("alt_cnt_m1", 64'(n_rdv1), 64'd3);

        // 4: only m1, 5 back-to-back reads
        for (int c = 0; c < 5; c++) begin
            drive(1, 1'b1, 1'b0, 10'(10'h3FF - c), 4'hF, 32'h0);
            @(negedge clk);
            chk("solo_wait", m_waitrequest, 2'b01);
            if (c > 0) begin
                chk("solo_rdv", m_readdatavalid, 2'b10);
                chk("solo_data", m_readdata, pat(10'(10'h3FF - (c - 1))));
            end
            tick();
        end
        idle();
        @(negedge clk);
        chk("solo_rdv_last", m_readdatavalid, 2'b10);
        chk("solo_data_last", m_readdata, pat(10'h3FB));

        // 5: byte-enabled write over all-ones
        drive(1, 1'b0, 1'b1, 10'h010, 4'hF, 32'hFFFFFFFF);
        tick();
        drive(1, 1'b0, 1'b1, 10'h010, 4'b0101, 32'h11223344);
        @(negedge clk);
        chk("be_mem_be", mem_byteenable, 4'b0101);
        tick();
        drive(1, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
        tick();
        idle();
        @(negedge clk);
        chk("be_rdv", m_readdatavalid, 2'b10);
        chk("be_data", m_readdata, 32'hFF22FF44);

        // 6: grant counters
        do_reset();
        @(negedge clk);
        chk("gc_reset", grant_count, 32'h0);
        drive(0, 1'b1, 1'b0, 10'h000, 4'hF, 32'h0);
        repeat (10) tick();
        @(negedge clk);
        chk("gc0_10", grant_count[15:0], STATS ? 16'd10 : 16'd0);
        repeat (70000) tick();
        @(negedge clk);
        chk("gc0_sat", grant_count[15:0], STATS ? 16'hFFFF : 16'h0);
        chk("gc1_zero", grant_count[31:16], 16'h0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
